// File: rtl/mtx_in_cond_if.sv
// Signal bundle for the MTX input conditioner: sample/tick strobes, the two
// candidate sources with their select, and the conditioned outputs.
interface mtx_in_cond_if #(
  parameter int CNT_W = 16
);
  logic             ce01us;
  logic             ce1ms;
  logic             din;
  logic             mtx_int;
  logic             sel_int;
  logic             dout;
  logic             rise;
  logic             fall;
  logic             lost;
  logic [CNT_W-1:0] edge_cnt;

  // Driver side: supplies strobes and sources, observes the conditioned signal.
  modport master (
    output ce01us, ce1ms, din, mtx_int, sel_int,
    input  dout, rise, fall, lost, edge_cnt
  );

  // Conditioner side.
  modport slave (
    input  ce01us, ce1ms, din, mtx_int, sel_int,
    output dout, rise, fall, lost, edge_cnt
  );
endinterface

// File: rtl/mtx_in_cond.sv
// Input conditioner for the frequency/period measurement stage: source mux,
// two-flop synchroniser, integrating glitch filter with hysteresis, edge
// detector, rising-edge counter and signal-loss watchdog.
module mtx_in_cond #(
  parameter int FLT_N   = 4,
  parameter int LOST_MS = 1000,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         rst,
  mtx_in_cond_if.slave bus
);

  localparam int FC_W = $clog2(FLT_N + 1);
  localparam int WD_W = $clog2(LOST_MS + 1);
  localparam logic [FC_W-1:0] FC_MAX = FC_W'(FLT_N);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(LOST_MS);

  logic             sel;
  logic             s1;
  logic             s2;
  logic [FC_W-1:0]  fc;
  logic [FC_W-1:0]  fc_nxt;
  logic             dout;
  logic             dout_d;
  logic             rise;
  logic             fall;
  logic             lost;
  logic [WD_W-1:0]  wd;
  logic [CNT_W-1:0] edge_cnt;

  // Source select; the only logic ahead of the synchroniser, so a switch
  // looks like ordinary input activity to the filter.
  assign sel = bus.sel_int ? bus.mtx_int : bus.din;

  // Two-flop synchroniser for the (possibly asynchronous) selected source.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse s1/s2 into one flop.
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sel;
      s2 <= s1;
    end
  end

  // Next value of the integrating filter counter, saturating at 0 and FLT_N.
  always_comb begin
    // NOTE: default assignment first so no path leaves fc_nxt unassigned,
    // which would otherwise infer a latch.
    fc_nxt = fc;
    if (bus.ce01us) begin
      if (s2 && (fc < FC_MAX)) begin
        fc_nxt = fc + 1'b1;
      end else if (!s2 && (fc != '0)) begin
        fc_nxt = fc - 1'b1;
      end
    end
  end

  // Filter state and hysteretic output: dout changes only at the saturation ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      fc   <= '0;
      dout <= 1'b0;
    end else begin
      fc <= fc_nxt;
      if (fc_nxt == FC_MAX) begin
        dout <= 1'b1;
      end else if (fc_nxt == '0) begin
        dout <= 1'b0;
      end
    end
  end

  // Registered edge detector: single-clk pulses one cycle after dout moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      dout_d <= dout;
      rise   <= dout & ~dout_d;
      fall   <= ~dout & dout_d;
    end
  end

  // Free-running rising-edge counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (rise) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // Signal-loss watchdog: a rise restarts it (and beats a coincident ms tick);
  // otherwise ms ticks count up to LOST_MS, where lost sets and wd saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd   <= '0;
      lost <= 1'b0;
    end else if (rise) begin
      wd   <= '0;
      lost <= 1'b0;
    end else if (bus.ce1ms && (wd < WD_MAX)) begin
      wd <= wd + 1'b1;
      if ((wd + 1'b1) == WD_MAX) begin
        lost <= 1'b1;
      end
    end
  end

  assign bus.dout     = dout;
  assign bus.rise     = rise;
  assign bus.fall     = fall;
  assign bus.lost     = lost;
  assign bus.edge_cnt = edge_cnt;

endmodule

// File: doc/mtx_in_cond.md
Name: mtx_in_cond

Overview:
- Input conditioner for the signal under measurement. It sits directly upstream of the frequency/period measurement stage and drives that stage's MTX input.
- Selects between the external pin and the internal test generator. It then synchronises, glitch-filters and edge-detects the selected signal.
- Also provides a signal-loss watchdog and a free-running edge counter for the display and status logic.

Parameters:
- FLT_N, 4, filter depth in ce01us samples (2..255); minimum stable time before the output changes.
- LOST_MS, 1000, ce1ms ticks without a rising edge before `lost` asserts (1..65535).
- CNT_W, 16, width of `edge_cnt`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ce01us  in  1  1-clk sample-enable strobe, every 0.1 us.
- ce1ms  in  1  1-clk tick strobe, every 1 ms.
- din  in  1  raw external input (pin JA1), asynchronous.
- mtx_int  in  1  internal test generator output, synchronous to clk.
- sel_int  in  1  1 = use mtx_int, 0 = use din (switch SW7).
- dout  out  1  filtered, synchronous signal; drives the measurement stage's MTX.
- rise  out  1  1-clk pulse on each dout 0->1 transition.
- fall  out  1  1-clk pulse on each dout 1->0 transition.
- lost  out  1  high when no rise has occurred for LOST_MS ticks.
- edge_cnt  out  CNT_W  count of rising edges since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst high at a clk edge): `dout`, `rise`, `fall` = 0; `lost` = 0; `edge_cnt` = 0; sync flops = 0; filter counter = 0; watchdog counter = 0. Reset is valid mid-operation and aborts any filtering in progress.
- Mux: `sel = sel_int ? mtx_int : din`, combinational. This mux is the only combinational logic ahead of the synchroniser.
- Synchroniser: two flops on every clk. `s2` is the synchronised value, 2 clk latency, with no ce gating.
- Integrating filter, counter `fc` in 0..FLT_N, updated only on cycles with ce01us = 1:
  - `s2` = 1 and `fc` < FLT_N: `fc` increments.
  - `s2` = 0 and `fc` > 0: `fc` decrements.
  - Otherwise `fc` holds (saturation at both ends).
- Filter output:
  - `dout` is set to 1 on the same edge at which `fc` becomes FLT_N.
  - `dout` is cleared to 0 on the same edge at which `fc` becomes 0.
  - Otherwise `dout` holds (hysteresis).
  - A pulse shorter than FLT_N samples never changes `dout`.
- Edge detect:
  - `dout_d` is `dout` delayed by 1 clk.
  - `rise` = `dout & ~dout_d`, registered, so it is high exactly 1 clk, in the cycle after `dout` rises. `fall` is symmetric.
- Edge counter: `edge_cnt` increments by 1 on each cycle with `rise` = 1, wrapping from all-ones to 0.
- Watchdog counter `wd`:
  - A cycle with `rise` = 1 clears `wd` to 0 and clears `lost`.
  - Else, a cycle with ce1ms = 1 and `wd` < LOST_MS increments `wd`.
  - `lost` is set on the edge at which `wd` reaches LOST_MS; `wd` then saturates.
  - Simultaneous `rise` and ce1ms: `rise` wins, so `wd` = 0.
- Source switch: a `sel_int` change is treated as ordinary input activity. The filter suppresses any glitch shorter than FLT_N samples. No counters are cleared on a switch.
- Total latency from a stable input change to `dout`: 2 clk for sync, plus up to FLT_N ce01us periods, plus 1 clk.
- Maximum passable input frequency is about 1/(2·FLT_N·0.1 us); this is a documented limit, not an error.

Test Plan:
- FLT_N = 4, din held 1 from reset release, ce01us every 5 clk -> `dout` rises after the 4th ce01us sample with `s2` = 1; `rise` is high exactly 1 clk, in the following cycle; `edge_cnt` = 1.
- Glitch rejection: din stable 1 with `dout` = 1, then a din low pulse lasting 3 samples -> `fc` goes 4→1 and recovers to 4; `dout` stays 1; no `fall`; `edge_cnt` unchanged.
- Square wave on din, 10 samples high / 10 low, 100 periods -> `edge_cnt` = 100; `dout` period 20 samples, duty 50%; `rise` and `fall` are each 100 single-clk pulses.
- LOST_MS = 5, din stuck 0 after one rise, ce1ms strobes -> `lost` asserts on the edge of the 5th ce1ms after the `rise`. The next din rising edge clears `lost` in the cycle `rise` is high.
- Simultaneous `rise` and ce1ms in the same clk -> `wd` = 0 afterwards and `lost` = 0.
- Source switch and reset mid-operation:
  - Step 1: `sel_int` toggled from din (held 0) to mtx_int (toggling) -> `dout` follows mtx_int after the filter delay.
  - Step 2: `rst` pulsed 1 clk while `fc` = 2 and `edge_cnt` = 37 -> all outputs and `fc` are 0 on the next edge; counting resumes from 0.
